// File: rtl/lcd_bus_pkg.sv
// Shared types and helpers for the LCD write bus: scheduler states,
// ctrl bit positions, requester indices and the long-command decode.
package lcd_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_EXEC
    } lcd_state_e;

    localparam int CTRL_RS = 2;
    localparam int CTRL_RW = 1;
    localparam int CTRL_E  = 0;

    localparam logic REQ_INIT = 1'b0;
    localparam logic REQ_CHAR = 1'b1;

    // Clear display (0x01) and return home (0x02/0x03) need the long execution wait.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return !rs && ((data == 8'h01) || (data == 8'h02) || (data == 8'h03));
    endfunction

endpackage

// File: rtl/lcd_wait_counter.sv
// Loadable down counter that parks at zero; zero_o flags the last cycle of a phase.
module lcd_wait_counter #(
    parameter int CNT_W = 17
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;

    // Load has priority; otherwise count down and hold at zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/lcd_bus_scheduler.sv
// Owns the HD44780 write bus, arbitrates two requesters and times every
// write through setup, enable pulse, hold and command execution.
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | bus free, arbitration open (lock keeps it with the owner)
// ST_SETUP | RS/data driven, E low for T_SETUP cycles
// ST_PULSE | E high for T_PW cycles
// ST_HOLD  | E low, RS/data held for T_HOLD cycles
// ST_EXEC  | waiting for the LCD to execute (T_EXEC or T_EXEC_LONG)
module lcd_bus_scheduler
    import lcd_bus_pkg::*;
#(
    parameter int T_SETUP     = 2,
    parameter int T_PW        = 12,
    parameter int T_HOLD      = 2,
    parameter int T_EXEC      = 2000,
    parameter int T_EXEC_LONG = 82000,
    parameter int CNT_W       = 17
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       req0_valid_i,
    input  logic       req0_rs_i,
    input  logic [7:0] req0_data_i,
    input  logic       req0_lock_i,
    input  logic       req1_valid_i,
    input  logic       req1_rs_i,
    input  logic [7:0] req1_data_i,
    input  logic       req1_lock_i,
    output logic       req0_ready_o,
    output logic       req1_ready_o,
    output logic [1:0] grant_o,
    output logic       busy_o,
    output logic [7:0] dout_o,
    output logic [2:0] ctrl_o
);

    lcd_state_e state_q;
    logic       owner_q;
    logic       owner_valid_q;
    logic       rs_q;
    logic [7:0] data_q;
    logic       e_q;

    logic [1:0]       valid;
    logic [1:0]       lock;
    logic [1:0]       ready;
    logic             idle;
    logic             lock_hold;
    logic             accept;
    logic             accept_sel;
    logic             cnt_zero;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_val;

    assign valid     = {req1_valid_i, req0_valid_i};
    assign lock      = {req1_lock_i, req0_lock_i};
    // Ready is held low during reset so nothing looks accepted before the first edge.
    assign idle      = (state_q == ST_IDLE) && rst_ni;
    assign lock_hold = owner_valid_q && lock[owner_q];

    // Arbitration: a locked owner keeps the bus, otherwise the init sequencer wins.
    always_comb begin
        ready = 2'b00;
        if (idle) begin
            if (lock_hold) begin
                ready[owner_q] = valid[owner_q];
            end else if (valid[REQ_INIT]) begin
                ready[REQ_INIT] = 1'b1;
            end else if (valid[REQ_CHAR]) begin
                ready[REQ_CHAR] = 1'b1;
            end
        end
    end

    assign accept     = |ready;
    assign accept_sel = ready[REQ_CHAR];

    // Counter reloads with (phase length - 1) on every state entry.
    always_comb begin
        cnt_load = 1'b0;
        cnt_val  = '0;
        case (state_q)
            ST_IDLE: begin
                cnt_load = accept;
                cnt_val  = CNT_W'(T_SETUP - 1);
            end
            ST_SETUP: begin
                cnt_load = cnt_zero;
                cnt_val  = CNT_W'(T_PW - 1);
            end
            ST_PULSE: begin
                cnt_load = cnt_zero;
                cnt_val  = CNT_W'(T_HOLD - 1);
            end
            ST_HOLD: begin
                cnt_load = cnt_zero;
                cnt_val  = is_long_cmd(rs_q, data_q) ? CNT_W'(T_EXEC_LONG - 1)
                                                     : CNT_W'(T_EXEC - 1);
            end
            default: begin
                cnt_load = 1'b0;
                cnt_val  = '0;
            end
        endcase
    end

    lcd_wait_counter #(
        .CNT_W (CNT_W)
    ) u_wait (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .zero_o     (cnt_zero)
    );

    // Bus FSM with registered RS/data/E; RS and data only change on an accept.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= ST_IDLE;
            owner_q       <= REQ_INIT;
            owner_valid_q <= 1'b0;
            rs_q          <= 1'b0;
            data_q        <= 8'h00;
            e_q           <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (owner_valid_q && !lock[owner_q]) begin
                        owner_valid_q <= 1'b0;
                    end
                    if (accept) begin
                        owner_q       <= accept_sel;
                        owner_valid_q <= 1'b1;
                        rs_q          <= accept_sel ? req1_rs_i : req0_rs_i;
                        data_q        <= accept_sel ? req1_data_i : req0_data_i;
                        state_q       <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (cnt_zero) begin
                        state_q <= ST_PULSE;
                        e_q     <= 1'b1;
                    end
                end
                ST_PULSE: begin
                    if (cnt_zero) begin
                        state_q <= ST_HOLD;
                        e_q     <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (cnt_zero) begin
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (cnt_zero) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    e_q     <= 1'b0;
                end
            endcase
        end
    end

    assign req0_ready_o    = ready[REQ_INIT];
    assign req1_ready_o    = ready[REQ_CHAR];
    assign busy_o          = (state_q != ST_IDLE);
    assign grant_o         = (busy_o || owner_valid_q) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    assign dout_o          = data_q;
    assign ctrl_o[CTRL_RS] = rs_q;
    assign ctrl_o[CTRL_RW] = 1'b0;
    assign ctrl_o[CTRL_E]  = e_q;

endmodule

// File: tb/tb_lcd_bus_scheduler.sv
// Bench for lcd_bus_scheduler: vector table of single beats, hand-written
// arbitration/lock/reset sequences, and a randomized run against a
// timeline model of the bus.
module tb_lcd_bus_scheduler;

    localparam int TS  = 2;
    localparam int TPW = 12;
    localparam int TH  = 2;
    localparam int TE  = 40;
    localparam int TEL = 150;
    localparam int TOT_N = TS + TPW + TH + TE;
    localparam int TOT_L = TS + TPW + TH + TEL;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0_valid = 1'b0, req0_rs = 1'b0, req0_lock = 1'b0;
    logic [7:0] req0_data = 8'h00;
    logic       req1_valid = 1'b0, req1_rs = 1'b0, req1_lock = 1'b0;
    logic [7:0] req1_data = 8'h00;
    logic       req0_ready, req1_ready, busy;
    logic [1:0] grant;
    logic [7:0] dout;
    logic [2:0] ctrl;

    int checks = 0;
    int errors = 0;

    lcd_bus_scheduler #(
        .T_SETUP(TS), .T_PW(TPW), .T_HOLD(TH), .T_EXEC(TE), .T_EXEC_LONG(TEL), .CNT_W(17)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req0_valid_i(req0_valid), .req0_rs_i(req0_rs), .req0_data_i(req0_data), .req0_lock_i(req0_lock),
        .req1_valid_i(req1_valid), .req1_rs_i(req1_rs), .req1_data_i(req1_data), .req1_lock_i(req1_lock),
        .req0_ready_o(req0_ready), .req1_ready_o(req1_ready),
        .grant_o(grant), .busy_o(busy), .dout_o(dout), .ctrl_o(ctrl)
    );

    always #5 clk = ~clk;

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input int r, input logic v, input logic rs, input logic [7:0] d, input logic lk);
        if (r == 0) begin
            req0_valid = v; req0_rs = rs; req0_data = d; req0_lock = lk;
        end else begin
            req1_valid = v; req1_rs = rs; req1_data = d; req1_lock = lk;
        end
    endtask

    function automatic logic rdy(input int r);
        return (r == 0) ? req0_ready : req1_ready;
    endfunction

    // One complete beat from requester r; returns idle cycles waited before ready.
    task automatic beat(input int r, input logic rs, input logic [7:0] d, input logic lk,
                        input int exp_total, input string tag, output int waited);
        int n, busy_cnt, e_first, e_cnt, bus_bad, rdy_bad;
        logic [1:0] g;
        g = (r == 0) ? 2'b01 : 2'b10;
        drive(r, 1'b1, rs, d, lk);
        #1;
        n = 0;
        while (!rdy(r) && n < 400) begin
            @(negedge clk); #1; n++;
        end
        waited = n;
        chk({tag, " accept"}, 32'(rdy(r)), 32'd1);
        @(negedge clk);
        drive(r, 1'b0, rs, d, lk);
        #1;
        busy_cnt = 0; e_first = -1; e_cnt = 0; bus_bad = 0; rdy_bad = 0;
        while (busy === 1'b1 && busy_cnt < 400) begin
            if (req0_ready || req1_ready) rdy_bad++;
            if (ctrl[0]) begin
                if (e_first < 0) e_first = busy_cnt;
                e_cnt++;
            end
            if (ctrl[2] !== rs || ctrl[1] !== 1'b0 || dout !== d || grant !== g) bus_bad++;
            busy_cnt++;
            @(negedge clk); #1;
        end
        chk({tag, " busy_len"}, busy_cnt, exp_total);
        chk({tag, " e_start"}, e_first, TS);
        chk({tag, " e_width"}, e_cnt, TPW);
        chk({tag, " bus_stable"}, bus_bad, 0);
        chk({tag, " ready_in_busy"}, rdy_bad, 0);
        chk({tag, " bus_after"}, {ctrl, dout}, {rs, 2'b00, d});
    endtask

    typedef struct {
        int         req;
        logic       rs;
        logic [7:0] data;
        logic       exp_long;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int w, n, bad;
        int m_idle_at, m_acc;
        logic m_own, m_ov, m_rs, m_busy, m_e, lh, er0, er1, acc_long;
        logic [7:0] m_data, d0, d1;
        logic v0, v1, rs0, rs1, l0, l1;
        logic [1:0] eg;

        tbl[0] = '{0, 1'b1, 8'h41, 1'b0};
        tbl[1] = '{0, 1'b0, 8'h01, 1'b1};
        tbl[2] = '{0, 1'b0, 8'h04, 1'b0};
        tbl[3] = '{1, 1'b0, 8'h02, 1'b1};
        tbl[4] = '{1, 1'b0, 8'h03, 1'b1};
        tbl[5] = '{0, 1'b0, 8'h00, 1'b0};
        tbl[6] = '{1, 1'b1, 8'h01, 1'b0};
        tbl[7] = '{0, 1'b0, 8'h38, 1'b0};

        // Reset values, with a valid request present during reset.
        req0_valid = 1'b1;
        #3;
        chk("rst ready0", 32'(req0_ready), 32'd0);
        chk("rst outputs", {grant, busy, ctrl, dout}, 32'd0);
        req0_valid = 1'b0;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // Vector table, back to back.
        for (int i = 0; i < 8; i++) begin
            beat(tbl[i].req, tbl[i].rs, tbl[i].data, 1'b0,
                 tbl[i].exp_long ? TOT_L : TOT_N, $sformatf("vec%0d", i), w);
            if (i > 0) chk($sformatf("vec%0d back_to_back", i), w, 0);
        end

        // Both valid, no locks: req0 first, req1 at the next idle.
        drive(0, 1'b1, 1'b1, 8'h30, 1'b0);
        drive(1, 1'b1, 1'b1, 8'h31, 1'b0);
        #1;
        chk("both readys", {req0_ready, req1_ready}, 2'b10);
        @(negedge clk);
        drive(0, 1'b0, 1'b1, 8'h30, 1'b0);
        #1;
        chk("both grant0", grant, 2'b01);
        n = 0;
        while (busy && n < 400) begin @(negedge clk); #1; n++; end
        chk("both req1 ready", 32'(req1_ready), 32'd1);
        chk("both idle grant", grant, 2'b01);
        @(negedge clk);
        drive(1, 1'b0, 1'b1, 8'h31, 1'b0);
        #1;
        chk("both grant1", {grant, dout}, {2'b10, 8'h31});
        n = 0;
        while (busy && n < 400) begin @(negedge clk); #1; n++; end
        @(negedge clk); #1;
        chk("both released grant", grant, 2'b00);

        // req1 locks the bus for three beats while req0 waits.
        beat(1, 1'b1, 8'h61, 1'b1, TOT_N, "lock1", w);
        drive(0, 1'b1, 1'b1, 8'h70, 1'b0);
        #1;
        chk("lock r0 blocked a", 32'(req0_ready), 32'd0);
        beat(1, 1'b1, 8'h62, 1'b1, TOT_N, "lock2", w);
        chk("lock2 wait", w, 0);
        beat(1, 1'b1, 8'h63, 1'b1, TOT_N, "lock3", w);
        chk("lock r0 blocked b", 32'(req0_ready), 32'd0);
        drive(1, 1'b0, 1'b1, 8'h63, 1'b0);
        #1;
        chk("lock released r0", 32'(req0_ready), 32'd1);
        beat(0, 1'b1, 8'h70, 1'b0, TOT_N, "lock_r0", w);
        chk("lock_r0 wait", w, 0);

        // Valid pulse while busy is ignored.
        drive(0, 1'b1, 1'b0, 8'h04, 1'b0);
        #1;
        chk("pulse accept", 32'(req0_ready), 32'd1);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 8'h04, 1'b0);
        repeat (5) @(negedge clk);
        drive(1, 1'b1, 1'b1, 8'hAA, 1'b0);
        #1;
        bad = (req1_ready !== 1'b0) ? 1 : 0;
        @(negedge clk);
        drive(1, 1'b0, 1'b1, 8'hAA, 1'b0);
        n = 0;
        while (n < TOT_N + 20) begin
            #1;
            if (req1_ready || dout !== 8'h04 || ctrl[2] !== 1'b0 || ctrl[1] !== 1'b0) bad++;
            if (n > TOT_N && busy) bad++;
            @(negedge clk); n++;
        end
        chk("pulse ignored", bad, 0);

        // Asynchronous reset while E is high.
        drive(0, 1'b1, 1'b1, 8'h5A, 1'b0);
        #1;
        @(negedge clk);
        drive(0, 1'b0, 1'b1, 8'h5A, 1'b0);
        n = 0;
        while (!ctrl[0] && n < 100) begin @(negedge clk); #1; n++; end
        chk("prerst e_high", 32'(ctrl[0]), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async rst outputs", {grant, busy, ctrl, dout}, 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        beat(1, 1'b0, 8'h38, 1'b0, TOT_N, "post_rst", w);
        chk("post_rst wait", w, 0);

        // Randomized run against a timeline model.
        rst_n = 1'b0;
        drive(0, 1'b0, 1'b0, 8'h00, 1'b0);
        drive(1, 1'b0, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        m_idle_at = 0; m_acc = -1000; m_own = 1'b0; m_ov = 1'b0; m_rs = 1'b0; m_data = 8'h00;
        for (int t = 0; t < 3000; t++) begin
            v0 = ($urandom_range(0, 3) == 0);
            v1 = ($urandom_range(0, 2) == 0);
            rs0 = 1'($urandom_range(0, 1));
            rs1 = 1'($urandom_range(0, 1));
            d0 = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 4)) : 8'($urandom);
            d1 = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 4)) : 8'($urandom);
            l0 = ($urandom_range(0, 3) == 0);
            l1 = ($urandom_range(0, 3) == 0);
            drive(0, v0, rs0, d0, l0);
            drive(1, v1, rs1, d1, l1);
            #1;
            m_busy = (t < m_idle_at);
            m_e = (t >= m_acc + 1 + TS) && (t < m_acc + 1 + TS + TPW);
            lh = m_ov && (m_own ? l1 : l0);
            er0 = 1'b0; er1 = 1'b0;
            if (!m_busy) begin
                if (lh) begin
                    if (m_own) er1 = v1; else er0 = v0;
                end else begin
                    er0 = v0;
                    er1 = v1 && !v0;
                end
            end
            eg = (m_busy || m_ov) ? (m_own ? 2'b10 : 2'b01) : 2'b00;
            chk($sformatf("rand t=%0d", t),
                {req0_ready, req1_ready, grant, busy, ctrl, dout},
                {er0, er1, eg, m_busy, m_rs, 1'b0, m_e, m_data});
            if (!m_busy) begin
                if (m_ov && !(m_own ? l1 : l0)) m_ov = 1'b0;
                if (er0 || er1) begin
                    m_own = er1;
                    m_ov = 1'b1;
                    m_rs = er1 ? rs1 : rs0;
                    m_data = er1 ? d1 : d0;
                    m_acc = t;
                    acc_long = !m_rs && (m_data >= 8'h01) && (m_data <= 8'h03);
                    m_idle_at = t + 1 + TS + TPW + TH + (acc_long ? TEL : TE);
                end
            end
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
